cmd_sequencer: RTL and testbench

- Central controller for the vector coprocessor. Replaces the separate command decoding and vector-write control.
- Consumes UART receive bytes and decodes opcodes.
- Streams LENGTH data bytes into vector register A or B via write-enable pulses.
- Launches processor operations and waits for their completion. Guards vector loads with an inter-byte timeout and reports protocol errors.

---
 rtl/coproc_pkg.sv | 40 ++++
 rtl/cmd_sequencer_if.sv | 28 ++
 rtl/cmd_sequencer_idle_timer.sv | 32 +++
 rtl/cmd_sequencer.sv | 124 ++++++++++++
 tb/tb_cmd_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the vector coprocessor: opcodes, controller states,
// error codes and default sizing.
package coproc_pkg;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_LENGTH         = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 40_000_000;

  localparam logic [7:0] OP_IDLE = 8'd0;
  localparam logic [7:0] OP_WR_A = 8'd97;
  localparam logic [7:0] OP_WR_B = 8'd98;
  localparam logic [7:0] OP_RD_A = 8'd99;
  localparam logic [7:0] OP_RD_B = 8'd100;
  localparam logic [7:0] OP_SUM  = 8'd101;
  localparam logic [7:0] OP_AVG  = 8'd102;
  localparam logic [7:0] OP_MAN  = 8'd103;
  localparam logic [7:0] OP_EUC  = 8'd104;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_OPCODE  = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_BUSY    = 2'b11
  } err_t;

  function automatic logic is_load_op(input logic [7:0] code);
    return (code == OP_WR_A) || (code == OP_WR_B);
  endfunction

  function automatic logic is_exec_op(input logic [7:0] code);
    return (code >= OP_RD_A) && (code <= OP_EUC);
  endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Handshake bundle between the command sequencer, the UART receiver,
// the vector registers and the processor.
interface cmd_sequencer_if
  import coproc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;
  logic             proc_done;
  logic [7:0]       op;
  logic             proc_start;
  logic             wea_A;
  logic             wea_B;
  logic [WIDTH-1:0] data_write;
  logic             busy;
  logic [1:0]       err_code;

  modport master (
    input  rx_data, rx_ready, proc_done,
    output op, proc_start, wea_A, wea_B, data_write, busy, err_code
  );

  modport slave (
    output rx_data, rx_ready, proc_done,
    input  op, proc_start, wea_A, wea_B, data_write, busy, err_code
  );
endinterface

// File: rtl/cmd_sequencer_idle_timer.sv
// Inter-byte watchdog: counts enabled cycles without a restart and pulses
// expired on the cycle the count reaches TIMEOUT_CYCLES-1.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 40_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic expired
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_r;
  logic          expired_s;

  // A restarting byte takes priority over an expiry in the same cycle.
  assign expired_s = enable && !restart && (cnt_r == LAST);
  assign expired   = expired_s;

  // Idle-cycle counter, cleared whenever the watch is inactive or restarted
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {TW{1'b0}};
    end else if (!enable || restart || expired_s) begin
      cnt_r <= {TW{1'b0}};
    end else begin
      cnt_r <= cnt_r + TW'(1);
    end
  end
endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: decodes UART opcodes, streams vector loads into
// register A or B, and launches processor operations.
module cmd_sequencer
  import coproc_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int LENGTH         = DEF_LENGTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  cmd_sequencer_if.master        bus
);
  localparam int CW = $clog2(LENGTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

  state_t        state_r;
  logic [CW-1:0] count_r;
  logic [7:0]    rx_byte_s;
  logic          load_active_s;
  logic          timer_expired_s;

  assign rx_byte_s     = 8'(bus.rx_data);
  assign load_active_s = (state_r == LOAD);

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (load_active_s),
    .restart (bus.rx_ready),
    .expired (timer_expired_s)
  );

  // Controller state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= IDLE;
      count_r        <= {CW{1'b0}};
      bus.op         <= OP_IDLE;
      bus.proc_start <= 1'b0;
      bus.wea_A      <= 1'b0;
      bus.wea_B      <= 1'b0;
      bus.data_write <= {WIDTH{1'b0}};
      bus.busy       <= 1'b0;
      bus.err_code   <= ERR_NONE;
    end else begin
      bus.proc_start <= 1'b0;
      bus.wea_A      <= 1'b0;
      bus.wea_B      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.rx_ready) begin
            if (is_load_op(rx_byte_s)) begin
              state_r      <= LOAD;
              bus.op       <= rx_byte_s;
              bus.busy     <= 1'b1;
              bus.err_code <= ERR_NONE;
              count_r      <= {CW{1'b0}};
            end else if (is_exec_op(rx_byte_s)) begin
              state_r        <= EXEC;
              bus.op         <= rx_byte_s;
              bus.busy       <= 1'b1;
              bus.err_code   <= ERR_NONE;
              bus.proc_start <= 1'b1;
            end else begin
              bus.err_code <= ERR_OPCODE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          // Every byte here is payload, never an opcode.
          if (bus.rx_ready) begin
            bus.data_write <= bus.rx_data;
            if (bus.op == OP_WR_A) begin
              bus.wea_A <= 1'b1;
            end else begin
              bus.wea_B <= 1'b1;
            end
            if (count_r == LAST_IDX) begin
              state_r  <= IDLE;
              bus.op   <= OP_IDLE;
              bus.busy <= 1'b0;
              count_r  <= {CW{1'b0}};
            end else begin
              count_r <= count_r + CW'(1);
            end
          end else if (timer_expired_s) begin
            state_r      <= IDLE;
            bus.op       <= OP_IDLE;
            bus.busy     <= 1'b0;
            bus.err_code <= ERR_TIMEOUT;
            count_r      <= {CW{1'b0}};
          end else begin
            state_r <= LOAD;
          end
        end
        EXEC: begin
          if (bus.rx_ready) begin
            bus.err_code <= ERR_BUSY;
          end else begin
            bus.err_code <= bus.err_code;
          end
          if (bus.proc_done) begin
            state_r  <= IDLE;
            bus.op   <= OP_IDLE;
            bus.busy <= 1'b0;
          end else begin
            state_r <= EXEC;
          end
        end
        default: begin
          state_r  <= IDLE;
          bus.op   <= OP_IDLE;
          bus.busy <= 1'b0;
          count_r  <= {CW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed, table-driven bench for cmd_sequencer with LENGTH=4 and
// TIMEOUT_CYCLES=100.
module tb_cmd_sequencer;
  import coproc_pkg::*;

  localparam int WIDTH = 8;
  localparam int LEN   = 4;
  localparam int TO    = 100;

  typedef struct {
    int         gap;
    logic [7:0] b;
    logic [7:0] op;
    logic       wa;
    logic       wb;
    logic       busy;
    logic       ps;
    logic [1:0] err;
    logic [7:0] data;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   n_wea_a = 0;
  int   n_wea_b = 0;
  vec_t vecs[$];

  cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cmd_sequencer #(
    .WIDTH(WIDTH), .LENGTH(LEN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sample the value held during the cycle just ending
  always @(posedge clk) begin
    if (bus.wea_A === 1'b1) n_wea_a++;
    if (bus.wea_B === 1'b1) n_wea_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] status();
    return {bus.op, bus.wea_A, bus.wea_B, bus.busy, bus.proc_start, bus.err_code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int gap, input logic [7:0] b, input logic [7:0] op,
                     input logic wa, input logic wb, input logic busy, input logic ps,
                     input logic [1:0] err, input logic [7:0] data);
    vec_t v;
    v = '{gap: gap, b: b, op: op, wa: wa, wb: wb, busy: busy, ps: ps, err: err, data: data};
    vecs.push_back(v);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      bus.rx_data  = vecs[i].b;
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      check($sformatf("row%0d_status", i), 32'(status()),
            32'({vecs[i].op, vecs[i].wa, vecs[i].wb, vecs[i].busy, vecs[i].ps, vecs[i].err}));
      if (vecs[i].wa || vecs[i].wb)
        check($sformatf("row%0d_data", i), 32'(bus.data_write), 32'(vecs[i].data));
    end
  endtask

  task automatic pulse_done();
    bus.proc_done = 1'b1;
    @(negedge clk);
    bus.proc_done = 1'b0;
  endtask

  initial begin
    int sa;
    int sb;
    // gap, byte, op, wea_A, wea_B, busy, proc_start, err, data
    add(2,  8'd97,  8'd97,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);   // 0
    add(20, 8'd10,  8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd10);
    add(20, 8'd20,  8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd20);
    add(20, 8'd30,  8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd30);
    add(20, 8'd40,  8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd40);   // 4
    add(3,  8'd98,  8'd98,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);    // 5
    add(1,  8'd97,  8'd98,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd97);
    add(1,  8'd98,  8'd98,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd98);
    add(1,  8'd99,  8'd98,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd99);
    add(1,  8'd100, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd100);  // 9
    add(2,  8'd101, 8'd101, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'd0);    // 10
    add(5,  8'd55,  8'd101, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'd0);    // 11
    add(2,  8'd102, 8'd102, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'd0);    // 12
    add(2,  8'd7,   8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0);    // 13
    add(2,  8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0);    // 14
    add(2,  8'd97,  8'd97,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);    // 15
    add(1,  8'd1,   8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1);
    add(1,  8'd2,   8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd2);    // 17
    add(2,  8'd97,  8'd97,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);    // 18
    add(1,  8'd5,   8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd5);
    add(1,  8'd6,   8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd6);
    add(1,  8'd7,   8'd97,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'd7);
    add(1,  8'd8,   8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd8);    // 22
    add(2,  8'd98,  8'd98,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);    // 23
    add(1,  8'd3,   8'd98,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd3);
    add(1,  8'd4,   8'd98,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd4);
    add(1,  8'd5,   8'd98,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd5);    // 26
    add(2,  8'h55,  8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0);    // 27
    add(2,  8'd103, 8'd103, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'd0);    // 28

    reset         = 1'b0;
    bus.rx_data   = 8'd0;
    bus.rx_ready  = 1'b0;
    bus.proc_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_status", 32'(status()), 32'd0);
    check("reset_data", 32'(bus.data_write), 32'd0);
    reset = 1'b1;

    // Load A with four bytes
    sa = n_wea_a; sb = n_wea_b;
    run_rows(0, 4);
    repeat (2) @(negedge clk);
    check("loadA_pulses_A", 32'(n_wea_a - sa), 32'd4);
    check("loadA_pulses_B", 32'(n_wea_b - sb), 32'd0);

    // Load B with opcode-valued payload
    sa = n_wea_a; sb = n_wea_b;
    run_rows(5, 9);
    repeat (2) @(negedge clk);
    check("loadB_pulses_B", 32'(n_wea_b - sb), 32'd4);
    check("loadB_pulses_A", 32'(n_wea_a - sa), 32'd0);

    // Exec with dropped byte, then completion
    sa = n_wea_a; sb = n_wea_b;
    run_rows(10, 11);
    repeat (3) @(negedge clk);
    check("exec_holds", 32'(status()), 32'({8'd101, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3}));
    pulse_done();
    check("exec_done", 32'(status()), 32'({8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3}));
    check("exec_no_wea", 32'((n_wea_a - sa) + (n_wea_b - sb)), 32'd0);
    run_rows(12, 12);
    pulse_done();
    check("exec2_done", 32'(status()), 32'({8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}));

    // Unknown opcodes
    run_rows(13, 14);

    // Load timeout boundary
    sa = n_wea_a;
    run_rows(15, 17);
    repeat (TO - 1) @(negedge clk);
    check("timeout_not_yet", 32'(status()), 32'({8'd97, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}));
    @(negedge clk);
    check("timeout_fired", 32'(status()), 32'({8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2}));
    repeat (5) @(negedge clk);
    check("timeout_pulses_A", 32'(n_wea_a - sa), 32'd2);

    // Load restarts from zero
    sa = n_wea_a;
    run_rows(18, 22);
    repeat (2) @(negedge clk);
    check("restart_pulses_A", 32'(n_wea_a - sa), 32'd4);

    // Reset in the middle of a load
    run_rows(23, 26);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midload_reset_status", 32'(status()), 32'd0);
    check("midload_reset_data", 32'(bus.data_write), 32'd0);
    sb = n_wea_b;
    run_rows(27, 27);
    repeat (2) @(negedge clk);
    check("post_reset_no_weaB", 32'(n_wea_b - sb), 32'd0);

    // proc_done and a byte in the same EXEC cycle
    run_rows(28, 28);
    repeat (2) @(negedge clk);
    bus.rx_data   = 8'd9;
    bus.rx_ready  = 1'b1;
    bus.proc_done = 1'b1;
    @(negedge clk);
    bus.rx_ready  = 1'b0;
    bus.proc_done = 1'b0;
    check("done_and_rx", 32'(status()), 32'({8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3}));
    pulse_done();
    check("done_in_idle_ignored", 32'(status()), 32'({8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3}));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
